weight_loader: RTL and testbench

//   Write-side sequencer for the 3-D kernel weight store. Accepts a byte stream of

---
 rtl/weight_loader_if.sv | 30 +++
 rtl/weight_loader.sv | 146 ++++++++++++++
 tb/tb_weight_loader.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/weight_loader_if.sv
// Signal bundle between a weight stream source (master) and weight_loader (slave):
// byte stream handshake, control/status, and the multi-lane weight-memory write port.
interface weight_loader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_SIZE  = 2,
    parameter int CHANNELS   = 3
);
    logic                                start;
    logic                                in_valid;
    logic [DATA_WIDTH-1:0]               in_data;
    logic                                in_ready;
    logic                                we;
    logic [CHANNELS-1:0][DATA_SIZE:0]    row_wr;
    logic [CHANNELS-1:0][DATA_SIZE:0]    col_wr;
    logic [CHANNELS-1:0][DATA_SIZE:0]    channel_wr;
    logic [CHANNELS-1:0][DATA_WIDTH-1:0] wr_data;
    logic                                busy;
    logic                                done;
    logic [15:0]                         checksum;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, we, row_wr, col_wr, channel_wr, wr_data, busy, done, checksum
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, we, row_wr, col_wr, channel_wr, wr_data, busy, done, checksum
    );
endinterface

// File: rtl/weight_loader.sv
// Packs a weight byte stream into CHANNELS-lane writes for the 3-D kernel weight store.
// Optional running byte checksum enabled by defining WEIGHT_LOADER_CHECKSUM_EN.
module weight_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_SIZE  = 2,
    parameter int CHANNELS   = 3
) (
    input logic             clk,
    input logic             rst_n,
    weight_loader_if.slave  bus
);
    localparam int AW = DATA_SIZE + 1;
    localparam int LW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [AW-1:0] MAX_IDX   = AW'(DATA_SIZE);
    localparam logic [LW-1:0] LAST_LANE = LW'(CHANNELS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    state_t                              state;
    logic [AW-1:0]                       row_cnt;
    logic [AW-1:0]                       col_cnt;
    logic [LW-1:0]                       lane_cnt;
    logic [CHANNELS-1:0][DATA_WIDTH-1:0] lane_buf;
    logic [CHANNELS-1:0][DATA_WIDTH-1:0] wr_data_q;
    logic [CHANNELS-1:0][AW-1:0]         row_q;
    logic [CHANNELS-1:0][AW-1:0]         col_q;
    logic [CHANNELS-1:0][AW-1:0]         chan_q;
    logic                                in_ready_q;
    logic                                we_q;
    logic                                busy_q;
    logic                                done_q;
    logic                                accept;

    // in_ready_q is only ever set in LOAD, so this also gates acceptance to LOAD.
    assign accept = in_ready_q && bus.in_valid;

    // NOTE: every register here, including the lane buffer and write-port data, is reset;
    // it is a handful of flops, not a RAM, and the write port must read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            row_cnt    <= '0;
            col_cnt    <= '0;
            lane_cnt   <= '0;
            lane_buf   <= '0;
            wr_data_q  <= '0;
            row_q      <= '0;
            col_q      <= '0;
            chan_q     <= '0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout so every branch sees pre-edge state.
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state      <= LOAD;
                        row_cnt    <= '0;
                        col_cnt    <= '0;
                        lane_cnt   <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end

                LOAD: begin
                    if (accept) begin
                        lane_buf[lane_cnt] <= bus.in_data;
                        if (lane_cnt == LAST_LANE) begin
                            // Last lane bypasses the buffer so the write issues next cycle.
                            for (int i = 0; i < CHANNELS; i++) begin
                                wr_data_q[i] <= (i == CHANNELS - 1) ? bus.in_data : lane_buf[i];
                                row_q[i]     <= row_cnt;
                                col_q[i]     <= col_cnt;
                                chan_q[i]    <= AW'(i);
                            end
                            lane_cnt   <= '0;
                            in_ready_q <= 1'b0;
                            we_q       <= 1'b1;
                            state      <= WRITE;
                        end else begin
                            lane_cnt <= lane_cnt + 1'b1;
                        end
                    end
                end

                WRITE: begin
                    we_q <= 1'b0;
                    if (col_cnt == MAX_IDX) begin
                        col_cnt <= '0;
                        if (row_cnt == MAX_IDX) begin
                            row_cnt <= '0;
                            done_q  <= 1'b1;
                            state   <= DONE;
                        end else begin
                            row_cnt    <= row_cnt + 1'b1;
                            in_ready_q <= 1'b1;
                            state      <= LOAD;
                        end
                    end else begin
                        col_cnt    <= col_cnt + 1'b1;
                        in_ready_q <= 1'b1;
                        state      <= LOAD;
                    end
                end

                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.we         = we_q;
    assign bus.row_wr     = row_q;
    assign bus.col_wr     = col_q;
    assign bus.channel_wr = chan_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [15:0] cks_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cks_q <= '0;
        end else if (state == IDLE && bus.start) begin
            cks_q <= '0;
        end else if (accept) begin
            cks_q <= cks_q + 16'(bus.in_data);
        end
    end

    assign bus.checksum = cks_q;
`else
    assign bus.checksum = 16'h0;
`endif
endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench for weight_loader: random streams and stalls checked against a
// kernel-level model (byte array -> expected write list and byte sum).
module tb_weight_loader;
    localparam int DW     = 8;
    localparam int DS     = 2;
    localparam int CH     = 3;
    localparam int KDIM   = DS + 1;
    localparam int NBYTES = KDIM * KDIM * CH;
    localparam int NWR    = KDIM * KDIM;

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    localparam logic [15:0] CKS_RAMP = 16'd351;
    localparam logic [15:0] CKS_FF   = 16'h1AE5;
`else
    localparam logic [15:0] CKS_RAMP = 16'h0;
    localparam logic [15:0] CKS_FF   = 16'h0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    weight_loader_if #(.DATA_WIDTH(DW), .DATA_SIZE(DS), .CHANNELS(CH)) bus ();

    weight_loader #(.DATA_WIDTH(DW), .DATA_SIZE(DS), .CHANNELS(CH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: the kernel being streamed, writes seen so far, byte sum.
    logic [DW-1:0]               kern [NBYTES];
    int                          wr_idx;
    int                          exp_sum;
    logic [CH-1:0][DS:0]         last_row, last_col, last_chan;
    logic [CH-1:0][DW-1:0]       last_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_cks();
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        return exp_sum[15:0];
`else
        return 16'h0;
`endif
    endfunction

    // Advance one cycle and check the write port against the model at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (bus.we) begin
            if (wr_idx >= NWR) begin
                check("wr_extra", 32'(bus.we), 32'd0);
            end else begin
                for (int i = 0; i < CH; i++) begin
                    last_row[i]  = (DS + 1)'(wr_idx / KDIM);
                    last_col[i]  = (DS + 1)'(wr_idx % KDIM);
                    last_chan[i] = (DS + 1)'(i);
                    last_data[i] = kern[wr_idx * CH + i];
                end
                check("wr_row",   32'(bus.row_wr),     32'(last_row));
                check("wr_col",   32'(bus.col_wr),     32'(last_col));
                check("wr_chan",  32'(bus.channel_wr), 32'(last_chan));
                check("wr_data",  32'(bus.wr_data),    32'(last_data));
                check("wr_ready", 32'(bus.in_ready),   32'd0);
                check("wr_busy",  32'(bus.busy),       32'd1);
                wr_idx++;
            end
        end else begin
            check("hold_row",  32'(bus.row_wr),     32'(last_row));
            check("hold_col",  32'(bus.col_wr),     32'(last_col));
            check("hold_chan", 32'(bus.channel_wr), 32'(last_chan));
            check("hold_data", 32'(bus.wr_data),    32'(last_data));
        end
        if (bus.done) begin
            check("done_writes", wr_idx, NWR);
            check("done_cks",    32'(bus.checksum), 32'(exp_cks()));
        end
        if (!bus.busy) begin
            check("idle_cks",   32'(bus.checksum), 32'(exp_cks()));
            check("idle_ready", 32'(bus.in_ready), 32'd0);
        end
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("rst_we",    32'(bus.we),       32'd0);
        check("rst_ready", 32'(bus.in_ready), 32'd0);
        check("rst_busy",  32'(bus.busy),     32'd0);
        check("rst_done",  32'(bus.done),     32'd0);
        check("rst_cks",   32'(bus.checksum), 32'd0);
        check("rst_data",  32'(bus.wr_data),  32'd0);
        check("rst_row",   32'(bus.row_wr),   32'd0);
        wr_idx    = 0;
        exp_sum   = 0;
        last_row  = '0;
        last_col  = '0;
        last_chan = '0;
        last_data = '0;
        tick();
        check("rst_hold_we", 32'(bus.we), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", 32'(bus.busy), 32'd0);
    endtask

    task automatic push_byte(input logic [DW-1:0] v);
        int budget;
        budget       = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        while (!bus.in_ready && budget < 20) begin
            tick();
            budget++;
        end
        if (!bus.in_ready) begin
            check("ready_timeout", 32'(bus.in_ready), 32'd1);
        end else begin
            exp_sum += int'(v);
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    // mode 0: no gaps; 1: 5-cycle stall before byte 5; 2: random gaps with stray starts.
    task automatic load_kernel(input int n_bytes, input int mode, input bit start_on_done);
        int gap;
        bus.start = 1'b1;
        exp_sum   = 0;
        wr_idx    = 0;
        tick();
        bus.start = 1'b0;
        check("busy_rise",  32'(bus.busy),     32'd1);
        check("ready_rise", 32'(bus.in_ready), 32'd1);
        for (int n = 0; n < n_bytes; n++) begin
            gap = 0;
            if (mode == 1 && n == 5) gap = 5;
            if (mode == 2 && $urandom_range(0, 3) == 0) gap = int'($urandom_range(1, 3));
            for (int j = 0; j < gap; j++) begin
                if (mode == 2 && $urandom_range(0, 2) == 0) bus.start = 1'b1;
                tick();
                bus.start = 1'b0;
                check("stall_we",    32'(bus.we),       32'd0);
                check("stall_ready", 32'(bus.in_ready), 32'd1);
                check("stall_busy",  32'(bus.busy),     32'd1);
            end
            push_byte(kern[n]);
            if (n % CH == CH - 1) check("wr_lat", 32'(bus.we), 32'd1);
        end
        if (n_bytes == NBYTES) begin
            tick();
            check("done_pulse", 32'(bus.done), 32'd1);
            check("done_busy",  32'(bus.busy), 32'd1);
            if (start_on_done) bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            check("done_clear", 32'(bus.done), 32'd0);
            check("busy_fall",  32'(bus.busy), 32'd0);
            check("writes_total", wr_idx, NWR);
        end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        wr_idx       = 0;
        exp_sum      = 0;
        @(negedge clk);
        do_reset();

        // Ramp 0..26, back-to-back bytes.
        for (int n = 0; n < NBYTES; n++) kern[n] = DW'(n);
        load_kernel(NBYTES, 0, 1'b0);
        check("ramp_cks", 32'(bus.checksum), 32'(CKS_RAMP));

        // Stall between bytes 4 and 5.
        for (int n = 0; n < NBYTES; n++) kern[n] = DW'($urandom);
        load_kernel(NBYTES, 1, 1'b0);

        // Stray starts during LOAD and on the done cycle, then a start right after busy falls.
        for (int n = 0; n < NBYTES; n++) kern[n] = DW'($urandom);
        load_kernel(NBYTES, 2, 1'b1);
        for (int n = 0; n < NBYTES; n++) kern[n] = DW'($urandom);
        load_kernel(NBYTES, 2, 1'b0);

        // Abort after 13 bytes, then a clean reload.
        for (int n = 0; n < NBYTES; n++) kern[n] = DW'($urandom);
        load_kernel(13, 0, 1'b0);
        do_reset();
        load_kernel(NBYTES, 0, 1'b0);

        // Two all-0xFF kernels back to back.
        for (int n = 0; n < NBYTES; n++) kern[n] = 8'hFF;
        load_kernel(NBYTES, 0, 1'b0);
        check("ff_cks_1", 32'(bus.checksum), 32'(CKS_FF));
        load_kernel(NBYTES, 2, 1'b0);
        check("ff_cks_2", 32'(bus.checksum), 32'(CKS_FF));

        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < NBYTES; n++) kern[n] = DW'($urandom);
            load_kernel(NBYTES, 2, 1'b1);
        end

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
